ssd_ctrl_s_axi_regs: RTL and testbench

//  AXI4-Lite slave register file: the S00_AXI responder inside ssd_ctrl, answering PS/VIP master
//  AXI4LITE_WRITE_BURST/READ_BURST accesses. Holds NUM_REGS 32-bit read/write control registers,

---
 rtl/ssd_ctrl_s_axi_regs.sv | 194 +++++++++++++++++++
 tb/tb_ssd_ctrl_s_axi_regs.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_ctrl_s_axi_regs.sv
`default_nettype none
// ==========================================================================
// Module : ssd_ctrl_s_axi_regs
// AXI4-Lite slave register file for ssd_ctrl with per-register write strobes.
// Rev    : 1.0
// ==========================================================================
module ssd_ctrl_s_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]          reg_out,
  output logic [NUM_REGS-1:0]             reg_wr_pulse
);

  localparam int                c_idx_w    = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [c_idx_w:0]  c_num_regs = (c_idx_w + 1)'(NUM_REGS);
  localparam logic [1:0]        c_okay     = 2'b00;
  localparam logic [1:0]        c_slverr   = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic [0:0] {R_IDLE, R_RESP} rstate_t;

  wstate_t              r_wstate;
  rstate_t              r_rstate;
  logic                 r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]           r_bresp, r_rresp;
  logic [31:0]          r_rdata;
  logic [c_idx_w-1:0]   r_aw_idx;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic [NUM_REGS-1:0]  r_wr_pulse;

  logic                 w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [c_idx_w-1:0]   w_wr_idx, w_rd_idx;
  logic [31:0]          w_wr_data, w_wr_mask, w_rd_data;
  logic [3:0]           w_wr_strb;
  logic                 w_wr_mapped, w_rd_mapped;
  logic [NUM_REGS-1:0]  w_wr_sel;
  logic                 w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_aw_hs = S_AXI_AWVALID & r_awready;
  assign w_w_hs  = S_AXI_WVALID  & r_wready;
  assign w_ar_hs = S_AXI_ARVALID & r_arready;

  // The commit edge is whichever edge completes the second of the AW/W handshakes.
  assign w_commit = ((r_wstate == W_IDLE)    & w_aw_hs & w_w_hs) |
                    ((r_wstate == W_HAVE_AW) & w_w_hs) |
                    ((r_wstate == W_HAVE_W)  & w_aw_hs);

  assign w_wr_idx    = w_aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : r_aw_idx;
  assign w_wr_data   = w_w_hs  ? S_AXI_WDATA : r_wdata;
  assign w_wr_strb   = w_w_hs  ? S_AXI_WSTRB : r_wstrb;
  assign w_wr_mapped = {1'b0, w_wr_idx} < c_num_regs;
  assign w_rd_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_rd_mapped = {1'b0, w_rd_idx} < c_num_regs;

  always_comb begin
    w_wr_mask = '0;
    for (int b = 0; b < 4; b++) w_wr_mask[8*b +: 8] = {8{w_wr_strb[b]}};
  end

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
      logic [31:0] r_q;
      assign w_wr_sel[k] = w_commit & w_wr_mapped & (w_wr_idx == c_idx_w'(k));
      assign reg_out[32*k +: 32] = r_q;
      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)           r_q <= '0;
        else if (w_wr_sel[k]) r_q <= (r_q & ~w_wr_mask) | (w_wr_data & w_wr_mask);
      end
    end
  endgenerate

  // Samples register state before any same-edge write lands.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (w_rd_idx == c_idx_w'(k)) w_rd_data = reg_out[32*k +: 32];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wstate   <= W_IDLE;
      r_awready  <= 1'b1;
      r_wready   <= 1'b1;
      r_bvalid   <= 1'b0;
      r_bresp    <= c_okay;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_wr_sel;
      if (w_commit) begin
        r_wstate  <= W_RESP;
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_mapped ? c_okay : c_slverr;
      end else begin
        case (r_wstate)
          W_IDLE: begin
            if (w_aw_hs) begin
              r_aw_idx  <= w_wr_idx;
              r_awready <= 1'b0;
              r_wstate  <= W_HAVE_AW;
            end else if (w_w_hs) begin
              r_wdata  <= S_AXI_WDATA;
              r_wstrb  <= S_AXI_WSTRB;
              r_wready <= 1'b0;
              r_wstate <= W_HAVE_W;
            end
          end
          W_RESP: begin
            if (S_AXI_BREADY) begin
              r_bvalid  <= 1'b0;
              r_bresp   <= c_okay;
              r_awready <= 1'b1;
              r_wready  <= 1'b1;
              r_wstate  <= W_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rresp   <= c_okay;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata   <= w_rd_mapped ? w_rd_data : 32'h0;
            r_rresp   <= w_rd_mapped ? c_okay : c_slverr;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_RESP;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign reg_wr_pulse  = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ssd_ctrl_s_axi_regs.sv
`default_nettype none
// Testbench for ssd_ctrl_s_axi_regs: directed and random AXI4-Lite traffic
// checked against an array-based register model.
module tb_ssd_ctrl_s_axi_regs;
  localparam int AW = 5;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [NR*32-1:0] reg_out;
  logic [NR-1:0] reg_wr_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [NR];

  always #5 clk = ~clk;

  ssd_ctrl_s_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int d_aw, input int d_w, input int b_wait, input bit stall_aw);
    bit aw_pend, w_pend, aw_hs, w_hs, mapped;
    int cyc, idx;
    logic [1:0]    exp_resp;
    logic [NR-1:0] exp_pulse;
    idx = int'(addr) / 4;
    mapped = idx < NR;
    exp_resp = mapped ? 2'b00 : 2'b10;
    exp_pulse = mapped ? NR'(1 << idx) : '0;
    aw_pend = 1; w_pend = 1; cyc = 0;
    while (aw_pend || w_pend) begin
      @(negedge clk);
      if (cyc > 100) begin
        chk("wr_handshake_timeout", 1, 0);
        break;
      end
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = aw_pend && cyc >= d_aw;
      wvalid  = w_pend && cyc >= d_w;
      chk("awready_wait", awready, aw_pend);
      chk("wready_wait", wready, w_pend);
      chk("bvalid_pre", bvalid, 0);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk);
      if (aw_hs) aw_pend = 0;
      if (w_hs)  w_pend  = 0;
      cyc++;
    end
    @(negedge clk);
    awvalid = 0;
    wvalid  = 0;
    if (mapped)
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    chk("bvalid_latency", bvalid, 1);
    chk("bresp", bresp, exp_resp);
    chk("wr_pulse", reg_wr_pulse, exp_pulse);
    chk("reg_out_after_wr", reg_out, model_vec());
    for (int i = 0; i < b_wait; i++) begin
      awvalid = stall_aw;
      awaddr  = '0;
      @(posedge clk);
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1);
      chk("bresp_hold", bresp, exp_resp);
      chk("awready_stall", awready, 0);
      chk("wready_stall", wready, 0);
      chk("wr_pulse_clear", reg_wr_pulse, 0);
    end
    awvalid = 0;
    bready  = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0;
    chk("bvalid_drop", bvalid, 0);
    chk("awready_back", awready, 1);
    chk("wready_back", wready, 1);
    chk("wr_pulse_end", reg_wr_pulse, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int d_ar, input int r_wait);
    bit hs, mapped;
    int idx, cyc;
    logic [31:0] exp_data;
    idx = int'(addr) / 4;
    mapped = idx < NR;
    exp_data = mapped ? model[idx] : 32'h0;
    cyc = 0;
    hs = 0;
    while (!hs) begin
      @(negedge clk);
      if (cyc > 100) begin
        chk("rd_handshake_timeout", 1, 0);
        break;
      end
      araddr  = addr;
      arvalid = cyc >= d_ar;
      chk("arready_idle", arready, 1);
      hs = arvalid && arready;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    arvalid = 0;
    chk("rvalid_latency", rvalid, 1);
    chk("rdata", rdata, exp_data);
    chk("rresp", rresp, mapped ? 2'b00 : 2'b10);
    chk("arready_busy", arready, 0);
    for (int i = 0; i < r_wait; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_hold", rdata, exp_data);
    end
    rready = 1;
    @(posedge clk);
    @(negedge clk);
    rready = 0;
    chk("rvalid_drop", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  initial begin
    logic [31:0] old_v, new_v;
    rst = 1;
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    for (int k = 0; k < NR; k++) model[k] = '0;
    #200;
    rst = 0;
    #1;
    chk("rst_reg_out", reg_out, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_pulse", reg_wr_pulse, 0);

    for (int k = 0; k < NR; k++) do_write(AW'(4*k), 32'(k + 1), 4'hF, 0, 0, 0, 0);
    for (int k = 0; k < NR; k++) do_read(AW'(4*k), 0, 0);
    chk("seq_reg2", reg_out[64 +: 32], 32'h3);

    do_write(5'h08, 32'hDEADBEEF, 4'hF, 3, 0, 0, 0);
    do_write(5'h04, 32'h11223344, 4'hF, 0, 3, 0, 0);
    chk("w_first_reg2", reg_out[64 +: 32], 32'hDEADBEEF);
    chk("aw_first_reg1", reg_out[32 +: 32], 32'h11223344);

    do_write(5'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0);
    chk("strb_merge", reg_out[32 +: 32], 32'h11BB33DD);
    do_write(5'h0C, 32'h12345678, 4'b0000, 1, 0, 0, 0);

    do_write(5'h00, 32'hCAFEF00D, 4'hF, 0, 0, 10, 1);

    do_write(5'h14, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0);
    do_read(5'h14, 0, 0);
    chk("unmapped_no_change", reg_out, model_vec());

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      else
        do_read(AW'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Read and write committing to one register on the same edge.
    new_v = $urandom;
    @(negedge clk);
    old_v = model[1];
    awaddr = 5'h05; wdata = new_v; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 5'h06; arvalid = 1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    model[1] = new_v;
    chk("same_edge_rdata_old", rdata, old_v);
    chk("same_edge_reg_new", reg_out, model_vec());
    chk("same_edge_pulse", reg_wr_pulse, 4'b0010);
    bready = 1; rready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0; rready = 0;
    chk("same_edge_bdone", bvalid, 0);
    chk("same_edge_rdone", rvalid, 0);

    // Reset dropped in while a read response is pending.
    araddr = 5'h00; arvalid = 1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    chk("pre_rst_rvalid", rvalid, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_rvalid", rvalid, 0);
    chk("async_rst_regs", reg_out, 0);
    chk("async_rst_arready", arready, 1);
    for (int k = 0; k < NR; k++) model[k] = '0;
    @(negedge clk);
    rst = 0;
    do_read(5'h0C, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
